// File: rtl/rover_pkg.sv
// ---------------------------------------------------------------------------
// rover_pkg
// Shared definitions for the rover navigation block:
//   - clog2()     : width helper for location encodings
//   - loc_ok()    : range check used for table rows, destinations and target
//   - step_e      : classification of one navigation step
//   - LOC_*       : named campus locations (HOME is the reset location)
// ---------------------------------------------------------------------------
package rover_pkg;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Compares at 32 bits so narrow location fields never produce a
    // constant-folded comparison when NUM_LOC is a power of two.
    function automatic logic loc_ok(input logic [31:0] v, input logic [31:0] n);
        return v < n;
    endfunction

    localparam int DEF_NUM_LOC = 8;
    localparam int DEF_LOC_W   = clog2(DEF_NUM_LOC);

    // Campus map locations.
    localparam int LOC_HOME    = 0;
    localparam int LOC_GATE    = 1;
    localparam int LOC_LIBRARY = 2;
    localparam int LOC_LAB     = 3;
    localparam int LOC_CAFE    = 4;
    localparam int LOC_DORM    = 5;
    localparam int LOC_GYM     = 6;
    localparam int LOC_QUAD    = 7;

    typedef enum logic [1:0] {
        STEP_IDLE,     // no qualified step this cycle
        STEP_MOVE,     // step to a different location
        STEP_STAY,     // step whose destination is the current location
        STEP_RECOVER   // current location is out of range, return home
    } step_e;

endpackage

// File: rtl/rover_nav_if.sv
// ---------------------------------------------------------------------------
// rover_nav_if
// Bundles the command-decoder side (step + table programming + target) and
// the telemetry side (location and flags) of the navigation FSM.
//   master : command decoder / telemetry logger view
//   slave  : rover_nav_fsm view
// ---------------------------------------------------------------------------
interface rover_nav_if #(
    parameter int LOC_W = 3,
    parameter int HOP_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_we;
    logic [LOC_W-1:0] cfg_loc;
    logic             cfg_in;
    logic [LOC_W-1:0] cfg_next;
    logic [LOC_W-1:0] target;
    logic [LOC_W-1:0] state;
    logic             arrived;
    logic [HOP_W-1:0] hop_count;
    logic             stalled;
    logic             cfg_err;

    modport master (
        output in, in_valid, cfg_we, cfg_loc, cfg_in, cfg_next, target,
        input  state, arrived, hop_count, stalled, cfg_err
    );

    modport slave (
        input  in, in_valid, cfg_we, cfg_loc, cfg_in, cfg_next, target,
        output state, arrived, hop_count, stalled, cfg_err
    );
endinterface

// File: rtl/rover_nav_table.sv
// ---------------------------------------------------------------------------
// rover_nav_table
// Programmable next-location table, NUM_LOC rows x 2 edges x LOC_W bits.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset (loads defaults)
//   i_we, i_wr_loc,
//   i_wr_in, i_wr_next    : single write port, range-checked
//   i_rd_loc, i_rd_in     : combinational read address {row, edge}
//   o_rd_next, o_rd_legal : read data and "row is a valid location"
//   o_cfg_err             : registered one-cycle pulse on a rejected write
// Defaults: edge 0 stays in place, edge 1 advances to (loc+1) mod NUM_LOC.
// ---------------------------------------------------------------------------
module rover_nav_table
    import rover_pkg::*;
#(
    parameter int NUM_LOC = 8,
    parameter int LOC_W   = clog2(NUM_LOC)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [LOC_W-1:0] i_wr_loc,
    input  logic             i_wr_in,
    input  logic [LOC_W-1:0] i_wr_next,
    input  logic [LOC_W-1:0] i_rd_loc,
    input  logic             i_rd_in,
    output logic [LOC_W-1:0] o_rd_next,
    output logic             o_rd_legal,
    output logic             o_cfg_err
);
    logic [LOC_W-1:0] r_tbl [NUM_LOC][2];
    logic             r_cfg_err;
    logic             w_wr_ok;

    assign w_wr_ok = loc_ok(32'(i_wr_loc), 32'(NUM_LOC)) &&
                     loc_ok(32'(i_wr_next), 32'(NUM_LOC));

    // NOTE: the table is reset like any other register because the default
    // graph must be usable straight out of reset without programming.
    // NOTE: sequential state uses non-blocking assignments so every reader
    // sees pre-edge values; this is what makes a same-cycle step read the
    // old entry while the write lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int l = 0; l < NUM_LOC; l++) begin
                r_tbl[l][0] <= LOC_W'(l);
                r_tbl[l][1] <= LOC_W'((l + 1) % NUM_LOC);
            end
            r_cfg_err <= 1'b0;
        end else begin
            if (i_we && w_wr_ok) begin
                r_tbl[i_wr_loc][i_wr_in] <= i_wr_next;
            end
            r_cfg_err <= i_we && !w_wr_ok;
        end
    end

    always_comb begin
        o_rd_legal = loc_ok(32'(i_rd_loc), 32'(NUM_LOC));
        o_rd_next  = '0;
        if (o_rd_legal) begin
            o_rd_next = r_tbl[i_rd_loc][i_rd_in];
        end
    end

    assign o_cfg_err = r_cfg_err;
endmodule

// File: rtl/rover_nav_fsm.sv
// ---------------------------------------------------------------------------
// rover_nav_fsm
// Campus rover location FSM driven by a programmable next-location table.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : rover_nav_if slave (step input, table write, target, flags)
// Each qualified step (in_valid=1) moves to table[state][in], counts a hop
// (saturating), pulses arrived when landing on target, and tracks repeated
// self-loops for the sticky stalled flag.
// ---------------------------------------------------------------------------
module rover_nav_fsm
    import rover_pkg::*;
#(
    parameter int NUM_LOC     = DEF_NUM_LOC,
    parameter int HOME_LOC    = LOC_HOME,
    parameter int HOP_W       = 8,
    parameter int STALL_LIMIT = 4
) (
    input logic       clk,
    input logic       reset,
    rover_nav_if.slave bus
);
    localparam int LOC_W = clog2(NUM_LOC);

    logic [LOC_W-1:0] r_state,     w_state_nxt;
    logic [HOP_W-1:0] r_hops,      w_hops_nxt;
    logic [HOP_W-1:0] r_stall_cnt, w_stall_cnt_nxt;
    logic             r_arrived,   w_arrived_nxt;
    logic             r_stalled,   w_stalled_nxt;
    logic [LOC_W-1:0] w_tbl_next;
    logic             w_row_legal;
    logic [LOC_W-1:0] w_dest;
    step_e            w_step;

    rover_nav_table #(.NUM_LOC(NUM_LOC), .LOC_W(LOC_W)) u_table (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_we      (bus.cfg_we),
        .i_wr_loc  (bus.cfg_loc),
        .i_wr_in   (bus.cfg_in),
        .i_wr_next (bus.cfg_next),
        .i_rd_loc  (r_state),
        .i_rd_in   (bus.in),
        .o_rd_next (w_tbl_next),
        .o_rd_legal(w_row_legal),
        .o_cfg_err (bus.cfg_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= LOC_W'(HOME_LOC);
            r_hops      <= '0;
            r_stall_cnt <= '0;
            r_arrived   <= 1'b0;
            r_stalled   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hops      <= w_hops_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_arrived   <= w_arrived_nxt;
            r_stalled   <= w_stalled_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_step          = STEP_IDLE;
        w_dest          = r_state;
        w_state_nxt     = r_state;
        w_hops_nxt      = r_hops;
        w_stall_cnt_nxt = r_stall_cnt;
        w_arrived_nxt   = 1'b0;
        w_stalled_nxt   = r_stalled;

        if (bus.in_valid) begin
            if (!w_row_legal) begin
                w_step = STEP_RECOVER;
                w_dest = LOC_W'(HOME_LOC);
            end else if (w_tbl_next == r_state) begin
                w_step = STEP_STAY;
                w_dest = w_tbl_next;
            end else begin
                w_step = STEP_MOVE;
                w_dest = w_tbl_next;
            end
        end

        unique case (w_step)
            STEP_IDLE: ;
            STEP_STAY: begin
                if (r_stall_cnt != HOP_W'(STALL_LIMIT)) begin
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                end
            end
            default: w_stall_cnt_nxt = '0;   // MOVE and RECOVER change location
        endcase

        if (w_step != STEP_IDLE) begin
            w_state_nxt = w_dest;
            if (r_hops != '1) begin
                w_hops_nxt = r_hops + 1'b1;
            end
            // An out-of-range target can never match a legal destination,
            // but the explicit check keeps that independent of encoding.
            w_arrived_nxt = (w_dest == bus.target) &&
                            loc_ok(32'(bus.target), 32'(NUM_LOC));
            if (w_stall_cnt_nxt == HOP_W'(STALL_LIMIT)) begin
                w_stalled_nxt = 1'b1;
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.hop_count = r_hops;
    assign bus.arrived   = r_arrived;
    assign bus.stalled   = r_stalled;
endmodule

// File: tb/tb_rover_nav_fsm.sv
// ---------------------------------------------------------------------------
// tb_rover_nav_fsm
// Directed bench for rover_nav_fsm: an 8-location instance covers the
// default graph, the programmed campus map, stall, write/step collision,
// gating, hop saturation and asynchronous reset; a 6-location instance
// covers rejected writes and wrap-around of a non power-of-two graph.
// ---------------------------------------------------------------------------
module tb_rover_nav_fsm;
    import rover_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   pulses;

    rover_nav_if #(.LOC_W(3), .HOP_W(8)) bus8 ();
    rover_nav_if #(.LOC_W(3), .HOP_W(8)) bus6 ();

    rover_nav_fsm #(.NUM_LOC(8), .HOME_LOC(LOC_HOME), .HOP_W(8), .STALL_LIMIT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus8)
    );

    rover_nav_fsm #(.NUM_LOC(6), .HOME_LOC(LOC_HOME), .HOP_W(8), .STALL_LIMIT(4)) dut6 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic step8(input logic dir);
        bus8.in       = dir;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
    endtask

    task automatic write8(input int loc, input int e, input int nxt);
        bus8.cfg_we   = 1'b1;
        bus8.cfg_loc  = 3'(loc);
        bus8.cfg_in   = e[0];
        bus8.cfg_next = 3'(nxt);
        tick();
        bus8.cfg_we   = 1'b0;
    endtask

    int campus [8][2] = '{
        '{LOC_HOME,    LOC_GATE},
        '{LOC_LIBRARY, LOC_CAFE},
        '{LOC_LAB,     LOC_CAFE},
        '{LOC_LAB,     LOC_HOME},
        '{LOC_QUAD,    LOC_DORM},
        '{LOC_LAB,     LOC_GYM},
        '{LOC_QUAD,    LOC_GYM},
        '{LOC_GATE,    LOC_DORM}
    };
    logic walk_in  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   walk_exp [8] = '{0, 1, 4, 7, 5, 6, 7, 5};

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus8.in = 1'b0; bus8.in_valid = 1'b0; bus8.cfg_we = 1'b0;
        bus8.cfg_loc = '0; bus8.cfg_in = 1'b0; bus8.cfg_next = '0; bus8.target = '0;
        bus6.in = 1'b0; bus6.in_valid = 1'b0; bus6.cfg_we = 1'b0;
        bus6.cfg_loc = '0; bus6.cfg_in = 1'b0; bus6.cfg_next = '0; bus6.target = '0;
        reset = 1'b0;
        #12;
        check("rst_state",   32'(bus8.state), 0);
        check("rst_hops",    32'(bus8.hop_count), 0);
        check("rst_arrived", 32'(bus8.arrived), 0);
        check("rst_stalled", 32'(bus8.stalled), 0);
        check("rst_cfg_err", 32'(bus8.cfg_err), 0);
        reset = 1'b1;
        tick();

        // Default graph: edge 1 advances, wrapping 7 -> 0.
        bus8.target = 3'd3;
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            step8(1'b1);
            check("dflt_state", 32'(bus8.state), 32'(k % 8));
            check("dflt_arrived", 32'(bus8.arrived), 32'((k % 8) == 3));
            if (bus8.arrived) pulses++;
        end
        check("dflt_hops", 32'(bus8.hop_count), 9);
        check("dflt_pulses", 32'(pulses), 1);
        check("dflt_no_stall", 32'(bus8.stalled), 0);

        // Programmed campus map, then a walk over it.
        do_reset();
        for (int l = 0; l < 8; l++) begin
            write8(l, 0, campus[l][0]);
            write8(l, 1, campus[l][1]);
            check("prog_cfg_err", 32'(bus8.cfg_err), 0);
        end
        check("prog_state_held", 32'(bus8.state), 0);
        check("prog_hops_held", 32'(bus8.hop_count), 0);
        bus8.target = 3'(LOC_QUAD);
        for (int k = 0; k < 8; k++) begin
            step8(walk_in[k]);
            check("map_state", 32'(bus8.state), 32'(walk_exp[k]));
            check("map_arrived", 32'(bus8.arrived), 32'(walk_exp[k] == LOC_QUAD));
        end
        check("map_hops", 32'(bus8.hop_count), 8);

        // Stall: four self-loops on HOME (also the target) raise stalled.
        do_reset();
        bus8.target = 3'(LOC_HOME);
        for (int k = 1; k <= 4; k++) begin
            step8(1'b0);
            check("stall_state", 32'(bus8.state), 0);
            check("stall_arrived_selfloop", 32'(bus8.arrived), 1);
            check("stall_flag", 32'(bus8.stalled), 32'(k == 4));
        end
        step8(1'b1);
        check("stall_move_state", 32'(bus8.state), 1);
        check("stall_sticky", 32'(bus8.stalled), 1);
        check("stall_hops", 32'(bus8.hop_count), 5);
        check("stall_move_arrived", 32'(bus8.arrived), 0);

        // Write/step collision on the entry being traversed.
        step8(1'b1);
        check("coll_pre_state", 32'(bus8.state), 2);
        bus8.cfg_we = 1'b1; bus8.cfg_loc = 3'd2; bus8.cfg_in = 1'b1; bus8.cfg_next = 3'd6;
        step8(1'b1);
        bus8.cfg_we = 1'b0;
        check("coll_old_entry", 32'(bus8.state), 3);
        write8(3, 0, 2);
        step8(1'b0);
        check("coll_back_to_2", 32'(bus8.state), 2);
        step8(1'b1);
        check("coll_new_entry", 32'(bus8.state), 6);
        check("coll_hops", 32'(bus8.hop_count), 9);

        // Gating: in_valid=0 holds everything, even while sitting on target.
        bus8.target = 3'd6;
        for (int k = 0; k < 10; k++) begin
            bus8.in = k[0];
            tick();
            check("gate_state", 32'(bus8.state), 6);
            check("gate_hops", 32'(bus8.hop_count), 9);
            check("gate_arrived", 32'(bus8.arrived), 0);
        end

        // Hop counter saturation at 255.
        bus8.in = 1'b1;
        bus8.in_valid = 1'b1;
        repeat (246) tick();
        check("sat_reach", 32'(bus8.hop_count), 255);
        tick();
        bus8.in_valid = 1'b0;
        check("sat_hold", 32'(bus8.hop_count), 255);

        // Asynchronous reset mid-walk at state 5, hop_count 12.
        do_reset();
        for (int k = 0; k < 5; k++) step8(1'b1);
        for (int k = 0; k < 7; k++) step8(1'b0);
        check("async_pre_state", 32'(bus8.state), 5);
        check("async_pre_hops", 32'(bus8.hop_count), 12);
        check("async_pre_stalled", 32'(bus8.stalled), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_state", 32'(bus8.state), 0);
        check("async_hops", 32'(bus8.hop_count), 0);
        check("async_stalled", 32'(bus8.stalled), 0);
        #1;
        reset = 1'b1;
        tick();

        // NUM_LOC=6: rejected writes leave the default table intact.
        bus6.cfg_we = 1'b1; bus6.cfg_loc = 3'd2; bus6.cfg_in = 1'b1; bus6.cfg_next = 3'd7;
        tick();
        bus6.cfg_we = 1'b0;
        check("n6_err_next", 32'(bus6.cfg_err), 1);
        tick();
        check("n6_err_pulse_end", 32'(bus6.cfg_err), 0);
        bus6.cfg_we = 1'b1; bus6.cfg_loc = 3'd6; bus6.cfg_in = 1'b0; bus6.cfg_next = 3'd0;
        tick();
        bus6.cfg_we = 1'b0;
        check("n6_err_loc", 32'(bus6.cfg_err), 1);
        bus6.target = 3'd7;
        bus6.in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            bus6.in_valid = 1'b1;
            tick();
            bus6.in_valid = 1'b0;
            check("n6_walk", 32'(bus6.state), 32'(k % 6));
            check("n6_no_arrive", 32'(bus6.arrived), 0);
        end
        bus6.cfg_we = 1'b1; bus6.cfg_loc = 3'd0; bus6.cfg_in = 1'b1; bus6.cfg_next = 3'd5;
        tick();
        bus6.cfg_we = 1'b0;
        check("n6_ok_write", 32'(bus6.cfg_err), 0);
        bus6.in_valid = 1'b1;
        tick();
        bus6.in_valid = 1'b0;
        check("n6_new_edge", 32'(bus6.state), 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
